// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller:
// FSM states, opcodes, ALU codes and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode: ALUOp plus instruction fields -> ALUControl.
// Ports: alu_op, funct3, op5, funct7b5 in; alu_control out.
module alu_decoder
    import ctrl_pkg::*;
(
    input  aluop_e      alu_op,
    input  logic [2:0]  funct3,
    input  logic        op5,
    input  logic        funct7b5,
    output logic [2:0]  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // sub only for R-type with funct7[5] set;
                    // addi never subtracts
                    3'b000:  alu_control = (op5 & funct7b5)
                                         ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle RV32I control FSM driving datapath muxes and enables.
// Ports: clk, resetn, op/funct3/funct7b5/Zero in; mux selects,
// write enables, illegal pulse and debug state_o out.
module control_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal,
    output logic [3:0] state_o
);

    state_e     state_q;
    state_e     state_d;
    aluop_e     alu_op;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal_dec;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        alu_op      = ALUOP_ADD;
        pc_update   = 1'b0;
        branch      = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        illegal_dec = 1'b0;
        result_src  = RES_ALUOUT;
        src_a       = SRCA_PC;
        src_b       = SRCB_RD2;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                src_a      = SRCA_PC;
                src_b      = SRCB_FOUR;
                result_src = RES_ALURESULT;
                pc_update  = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // ALU forms OldPC+imm so BEQ/JAL have a target
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (op)
                    OP_LOAD,
                    OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_EXECUTER;
                    OP_ITYPE: state_d = S_EXECUTEI;
                    OP_JAL:   state_d = S_JAL;
                    OP_BEQ:   state_d = S_BEQ;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a   = SRCA_RD1;
                src_b   = SRCB_IMM;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                result_src = RES_ALUOUT;
                adr_src    = 1'b1;
                state_d    = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                result_src = RES_ALUOUT;
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECUTER: begin
                src_a   = SRCA_RD1;
                src_b   = SRCB_RD2;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECUTEI: begin
                src_a   = SRCA_RD1;
                src_b   = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_JAL: begin
                // PC <- target (ALUOut); rd <- OldPC+4
                src_a      = SRCA_OLDPC;
                src_b      = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_update  = 1'b1;
                state_d    = S_ALUWB;
            end
            S_BEQ: begin
                src_a      = SRCA_RD1;
                src_b      = SRCB_RD2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

    always_comb begin
        case (op)
            OP_STORE: ImmSrc = IMM_S;
            OP_BEQ:   ImmSrc = IMM_B;
            OP_JAL:   ImmSrc = IMM_J;
            default:  ImmSrc = IMM_I;
        endcase
    end

    // Enables are gated by resetn so an aborted instruction
    // cannot commit anything during the reset cycle.
    assign PCWrite   = resetn & (pc_update | (branch & Zero));
    assign MemWrite  = resetn & mem_write;
    assign IRWrite   = resetn & ir_write;
    assign RegWrite  = resetn & reg_write;
    assign illegal   = resetn & illegal_dec;
    assign AdrSrc    = adr_src;
    assign ResultSrc = result_src;
    assign ALUSrcA   = src_a;
    assign ALUSrcB   = src_b;
    assign state_o   = state_q;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle RV32I controller that sequences every instruction and drives the datapath muxes and write enables. It is the initiator on the ALU interface: it generates ALUControl with the team encoding (add 000, sub 001, and 010, or 110, slt 101) and consumes the ALU zero flag for branches. It sits between the instruction register and the datapath of the multi-cycle CPU.

Parameters:
None. All encodings are fixed in ctrl_pkg.

Ports:
clk  input  1  system clock; all state changes on the rising edge
resetn  input  1  synchronous reset, active-low
op  input  7  instruction[6:0], taken from the instruction register
funct3  input  3  instruction[14:12]
funct7b5  input  1  instruction[30]
Zero  input  1  ALU zero flag (Z)
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register enable
ResultSrc  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  output  2  ALU A operand: 00 = PC, 01 = OldPC, 10 = RD1
ALUSrcB  output  2  ALU B operand: 00 = RD2, 01 = ImmExt, 10 = constant 4
ALUControl  output  3  ALU operation, team encoding above
ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
RegWrite  output  1  register file write enable
illegal  output  1  one-cycle pulse when an unsupported opcode is decoded
state_o  output  4  current state, for debug

Behaviour:
- The FSM is a Moore machine with a registered state. The only Mealy term is PCWrite = PCUpdate | (Branch & Zero).
- Any output not listed for a state is 0.
- FETCH(0): AdrSrc=0, IRWrite=1, A=00, B=10, ALUOp=add, ResultSrc=10, PCUpdate=1. Next state: DECODE.
- DECODE(1): A=01, B=01, ALUOp=add (computes the branch/jump target). Next state depends on op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other op -> FETCH, with illegal=1 for this cycle
- MEMADR(2): A=10, B=01, ALUOp=add. Next: MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD(3): ResultSrc=00, AdrSrc=1. Next: MEMWB.
- MEMWB(4): ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE(5): ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
- EXECUTER(6): A=10, B=00, ALUOp=funct. Next: ALUWB.
- ALUWB(7): ResultSrc=00, RegWrite=1. Next: FETCH.
- EXECUTEI(8): A=10, B=01, ALUOp=funct. Next: ALUWB.
- JAL(9): A=01, B=10, ALUOp=add, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- BEQ(10): A=10, B=00, ALUOp=sub, ResultSrc=00, Branch=1. Next: FETCH.
- State codes 11-15 are unreachable. If entered, the next state is FETCH and all enables are 0.
- Cycles per instruction: lw 5; sw, R-type, I-type and jal 4; beq 3; illegal opcode 2.
- ALU decode: ALUOp=add -> 000; ALUOp=sub -> 001; ALUOp=funct decodes on funct3:
  - 000 -> 001 (sub) when op[5] & funct7b5, otherwise 000 (add)
  - 010 -> 101 (slt)
  - 110 -> 110 (or)
  - 111 -> 010 (and)
  - any other funct3 -> 000
- ImmSrc is combinational from op in every state: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, everything else -> 00.
- Reset: while resetn=0 at a rising edge, the next state is FETCH.
- While resetn=0, PCWrite, IRWrite, MemWrite, RegWrite and illegal are forced to 0, independent of state and Zero.
- Reset asserted mid-instruction aborts the instruction: no write enable fires in any cycle where resetn=0.
- After resetn rises, the first FETCH cycle performs a normal fetch.
- Zero is ignored in every state except BEQ. When Zero=1 outside BEQ, PCWrite follows PCUpdate only.

Decomposition:
- ctrl_pkg holds:
  - the state enum, 4 bits
  - opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ
  - ALUControl codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  - ALUOp codes
  - the ResultSrc, ALUSrcA, ALUSrcB and ImmSrc select constants
- One combinational sub-module, alu_decoder (ALUOp, funct3, op[5], funct7b5 -> ALUControl), instantiated by control_unit.

Test Plan:
- Reset, then lw x1,4(x0) (0x00402083) -> states 0,1,2,3,4,0. RegWrite=1 only in MEMWB, ResultSrc=01 there, ImmSrc=00 throughout.
- add x3,x1,x2 (0x002081B3), then sub x3,x1,x2 (0x402081B3) -> EXECUTER ALUControl=000, then 001. ALUWB RegWrite=1. MemWrite=0 throughout.
- sw x2,8(x0) (0x00202423) -> states 0,1,2,5. MemWrite=1 and AdrSrc=1 only in state 5. ImmSrc=01.
- beq (0x00208463) with Zero=1 in BEQ -> PCWrite=1 and ALUControl=001. Repeat with Zero=0 -> PCWrite=0, next state FETCH.
- op=1111111 (0x0000007F) -> DECODE has illegal=1, then FETCH. No RegWrite or MemWrite asserted.
- Drop resetn during MEMWRITE of sw -> MemWrite=0 in that cycle. state_o=0 after the edge. Releasing resetn leads to a normal fetch with IRWrite=1.
